// File: rtl/stream_mux_pkg.sv
// ============================================================================
// Module : stream_mux_pkg
// Brief  : Shared types and the round-robin pick function for stream arbiters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stream_mux_pkg;

  localparam int C_MAX_CH    = 64;
  localparam int C_MAX_SEL_W = 6;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mux_state_e;

  typedef struct packed {
    logic                   found;
    logic [C_MAX_SEL_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or above ptr, wrapping within n_ch channels.
  function automatic rr_pick_t rr_pick(input logic [C_MAX_CH-1:0]    valid,
                                       input logic [C_MAX_SEL_W-1:0] ptr,
                                       input int unsigned            n_ch);
    rr_pick_t    res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < C_MAX_CH; k++) begin
      if (k < n_ch) begin
        idx = 32'(ptr) + k;
        if (idx >= n_ch) idx = idx - n_ch;
        if (!res.found && valid[idx[C_MAX_SEL_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = idx[C_MAX_SEL_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational channel pick plus registered round-robin pointer.
//          STREAM_MUX_FIXED_PRIO_EN removes the pointer (lowest index wins).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  i_valid,
  input  logic             i_adv,
  input  logic [SEL_W-1:0] i_adv_idx,
  output logic [SEL_W-1:0] o_pick,
  output logic             o_found
);

  logic [C_MAX_CH-1:0]    w_valid_ext;
  logic [C_MAX_SEL_W-1:0] w_ptr_ext;
  rr_pick_t               w_res;

  always_comb begin
    w_valid_ext             = '0;
    w_valid_ext[N_CH-1:0]   = i_valid;
  end

`ifdef STREAM_MUX_FIXED_PRIO_EN
  logic w_unused;
  assign w_ptr_ext = '0;
  assign w_unused  = ^{clk, rst_n, i_adv, i_adv_idx};
`else
  logic [SEL_W-1:0] r_rr_ptr;

  // Pointer moves just past the channel that completed a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (i_adv) begin
      r_rr_ptr <= (i_adv_idx == SEL_W'(N_CH - 1)) ? '0 : i_adv_idx + 1'b1;
    end
  end

  assign w_ptr_ext = C_MAX_SEL_W'(r_rr_ptr);
`endif

  assign w_res   = rr_pick(w_valid_ext, w_ptr_ext, N_CH);
  assign o_pick  = SEL_W'(w_res.idx);
  assign o_found = w_res.found;

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// ============================================================================
// Module : stream_mux_rr
// Brief  : N-channel valid/ready stream mux, packet-locking round-robin,
//          registered output. Option: STREAM_MUX_FIXED_PRIO_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  mux_state_e       r_state, w_state_nxt;
  logic [SEL_W-1:0] r_lock_ch, w_lock_ch_nxt;
  logic [SEL_W-1:0] w_pick, w_grant;
  logic             w_found, w_grant_vld, w_load_en, w_xfer, w_adv;
  logic [WIDTH-1:0] w_sel_data;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (in_valid),
    .i_adv     (w_adv),
    .i_adv_idx (w_grant),
    .o_pick    (w_pick),
    .o_found   (w_found)
  );

  assign w_load_en   = !out_valid || out_ready;
  assign w_grant     = (r_state == LOCKED) ? r_lock_ch : w_pick;
  assign w_grant_vld = (r_state == LOCKED) || w_found;
  assign w_xfer      = w_load_en && w_grant_vld && in_valid[w_grant];
  assign w_adv       = w_xfer && ((r_state == IDLE) || in_last[w_grant]);
  assign w_sel_data  = in_data[w_grant*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    if (rst_n && w_load_en && w_grant_vld) in_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_ch_nxt = r_lock_ch;
    case (r_state)
      IDLE: begin
        if (w_xfer && !in_last[w_grant]) begin
          w_state_nxt   = LOCKED;
          w_lock_ch_nxt = w_grant;
        end
      end
      LOCKED: begin
        if (w_xfer && in_last[w_grant]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Held beat stays frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        out_valid <= 1'b1;
        out_data  <= w_sel_data;
        out_last  <= in_last[w_grant];
        out_sel   <= w_grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// Module : tb_stream_mux_rr
// Brief  : Self-checking bench for stream_mux_rr (N_CH=8, WIDTH=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;

  localparam int N = 8;
`ifdef STREAM_MUX_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_valid, in_last, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_ready;
  logic [2:0]  out_sel;

  int n_checks = 0;
  int n_err    = 0;

  stream_mux_rr #(.N_CH(8), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: arbitration state plus the expected output register.
  int   m_ptr, m_lock_ch, m_os;
  bit   m_locked, m_ov, m_ol;
  logic [7:0] m_od;

  function automatic void model_reset();
    m_ptr = 0; m_lock_ch = 0; m_os = 0;
    m_locked = 0; m_ov = 0; m_ol = 0; m_od = '0;
  endfunction

  function automatic void model_eval(input logic [7:0] v, input logic ordy,
                                     output logic [7:0] rdy, output int g, output bit xfer);
    bit load, gv;
    int start;
    load = !m_ov || ordy;
    gv   = 0;
    g    = 0;
    if (m_locked) begin
      g  = m_lock_ch;
      gv = 1;
    end else begin
      start = FIXED_PRIO ? 0 : m_ptr;
      for (int k = 0; k < N; k++) begin
        if (!gv && v[(start + k) % N]) begin
          g  = (start + k) % N;
          gv = 1;
        end
      end
    end
    rdy  = (load && gv) ? 8'(1 << g) : 8'h00;
    xfer = load && gv && v[g];
  endfunction

  function automatic void model_update(input logic [7:0] v, input logic [7:0] l,
                                       input logic [63:0] d, input logic ordy);
    logic [7:0] rdy;
    int g;
    bit xfer;
    model_eval(v, ordy, rdy, g, xfer);
    if (xfer) begin
      m_od = d[g*8 +: 8];
      m_ol = l[g];
      m_os = g;
      m_ov = 1;
      if (!m_locked || l[g]) m_ptr = (g + 1) % N;
      m_locked  = !l[g];
      m_lock_ch = g;
    end else if (ordy) begin
      m_ov = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_data(input logic [3:0] beat);
    logic [63:0] d;
    for (int c = 0; c < N; c++) d[c*8 +: 8] = {4'(c), beat};
    return d;
  endfunction

  // One clock: drive after negedge, check in_ready, clock, check outputs.
  task automatic step(input logic [7:0] v, input logic [7:0] l, input logic [63:0] d,
                      input logic ordy, output logic [7:0] rdy_seen);
    logic [7:0] e_rdy;
    int g;
    bit x;
    in_valid = v; in_last = l; in_data = d; out_ready = ordy;
    #1;
    model_eval(v, ordy, e_rdy, g, x);
    rdy_seen = in_ready;
    chk("in_ready", in_ready, e_rdy);
    @(posedge clk);
    model_update(v, l, d, ordy);
    #1;
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_last", out_last, m_ol);
      chk("out_sel",  out_sel,  m_os);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] v;
    logic [7:0] l;
    logic [3:0] beat;
    logic       ordy;
    logic [7:0] e_rdy;
    logic       e_ov;
    logic [2:0] e_sel;
    logic [7:0] e_data;
    logic       e_last;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [7:0] rdy;
    vec_t r;

`ifdef STREAM_MUX_FIXED_PRIO_EN
    for (int i = 1; i <= 4; i++)
      tbl.push_back('{8'h24, 8'hFF, 4'(i), 1'b1, 8'h04, 1'b1, 3'd2, {4'h2, 4'(i)}, 1'b1});
`else
    tbl.push_back('{8'h24, 8'hFF, 4'd1, 1'b1, 8'h04, 1'b1, 3'd2, 8'h21, 1'b1});
    tbl.push_back('{8'h24, 8'hFF, 4'd2, 1'b1, 8'h20, 1'b1, 3'd5, 8'h52, 1'b1});
    tbl.push_back('{8'h24, 8'hFF, 4'd3, 1'b1, 8'h04, 1'b1, 3'd2, 8'h23, 1'b1});
    tbl.push_back('{8'h24, 8'hFF, 4'd4, 1'b1, 8'h20, 1'b1, 3'd5, 8'h54, 1'b1});
    tbl.push_back('{8'h0A, 8'h08, 4'd1, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11, 1'b0});
    tbl.push_back('{8'h0A, 8'h08, 4'd2, 1'b0, 8'h00, 1'b1, 3'd1, 8'h11, 1'b0});
    tbl.push_back('{8'h0A, 8'h08, 4'd2, 1'b0, 8'h00, 1'b1, 3'd1, 8'h11, 1'b0});
    tbl.push_back('{8'h0A, 8'h08, 4'd2, 1'b0, 8'h00, 1'b1, 3'd1, 8'h11, 1'b0});
    tbl.push_back('{8'h0A, 8'h08, 4'd2, 1'b1, 8'h02, 1'b1, 3'd1, 8'h12, 1'b0});
    tbl.push_back('{8'h0A, 8'h08, 4'd3, 1'b1, 8'h02, 1'b1, 3'd1, 8'h13, 1'b0});
    tbl.push_back('{8'h08, 8'h08, 4'd4, 1'b1, 8'h02, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{8'h0A, 8'h0A, 4'd4, 1'b1, 8'h02, 1'b1, 3'd1, 8'h14, 1'b1});
    tbl.push_back('{8'h0A, 8'h0A, 4'd5, 1'b1, 8'h08, 1'b1, 3'd3, 8'h35, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 4'd0, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{8'h40, 8'hFF, 4'd1, 1'b1, 8'h40, 1'b1, 3'd6, 8'h61, 1'b1});
    tbl.push_back('{8'h41, 8'hFF, 4'd2, 1'b1, 8'h01, 1'b1, 3'd0, 8'h02, 1'b1});
    tbl.push_back('{8'h41, 8'hFF, 4'd3, 1'b1, 8'h40, 1'b1, 3'd6, 8'h63, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 4'd0, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0});
`endif

    rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_out_sel",   out_sel,   3'd0);
    chk("rst_in_ready",  in_ready,  8'h00);
    @(negedge clk);

    for (int i = 0; i < 10; i++) step(8'h00, 8'h00, 64'h0, 1'b1, rdy);
    chk("idle_out_data", out_data, 8'h00);

    foreach (tbl[i]) begin
      r = tbl[i];
      step(r.v, r.l, mk_data(r.beat), r.ordy, rdy);
      chk($sformatf("tbl%0d_ready", i), rdy, r.e_rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, r.e_ov);
      if (r.e_ov) begin
        chk($sformatf("tbl%0d_sel", i),  out_sel,  r.e_sel);
        chk($sformatf("tbl%0d_data", i), out_data, r.e_data);
        chk($sformatf("tbl%0d_last", i), out_last, r.e_last);
      end
    end

    // Lock onto channel 4, then reset mid-packet.
    step(8'h10, 8'h00, mk_data(4'd6), 1'b1, rdy);
    step(8'h10, 8'h00, mk_data(4'd7), 1'b1, rdy);
    chk("lock4_sel", out_sel, 3'd4);
    in_valid = 8'h11; in_last = 8'h00;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_ready", in_ready, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h11, 8'hFF, mk_data(4'd8), 1'b1, rdy);
    chk("post_rst_ready", rdy, 8'h01);
    chk("post_rst_sel", out_sel, 3'd0);
    chk("post_rst_data", out_data, 8'h08);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(8'($urandom), 8'($urandom & $urandom), {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0), rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
